// File: rtl/cmp_pipe_pkg.sv
// Shared constants and helpers for the pipelined magnitude comparator:
// flag bit positions inside a lt/eq/gt triple and the per-bit leaf compare.
package cmp_pipe_pkg;

  localparam int CMP_LT   = 0;
  localparam int CMP_EQ   = 1;
  localparam int CMP_GT   = 2;
  localparam int TRIPLE_W = 3;

  typedef logic [TRIPLE_W-1:0] triple_t;

  function automatic triple_t leaf_triple(input logic ai, input logic bi);
    triple_t t;
    t         = '0;
    t[CMP_LT] = ~ai & bi;
    t[CMP_EQ] = ~(ai ^ bi);
    t[CMP_GT] = ai & ~bi;
    return t;
  endfunction

  // The sign bit of a two's complement operand weighs negatively, so its
  // lt/gt sense is inverted relative to an unsigned compare.
  function automatic triple_t swap_order(input triple_t t);
    triple_t s;
    s         = t;
    s[CMP_LT] = t[CMP_GT];
    s[CMP_GT] = t[CMP_LT];
    return s;
  endfunction

endpackage

// File: rtl/cmp_pipe_if.sv
// Valid/ready bundle for cmp_pipe: operand/tag input side and result output side.
interface cmp_pipe_if #(
  parameter int ORDER = 3,
  parameter int TW    = 4
) ();

  localparam int W = 1 << ORDER;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sgn;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          lt;
  logic          eq;
  logic          gt;
  logic [TW-1:0] out_tag;

  modport slave (
    input  in_valid, a, b, sgn, in_tag, out_ready,
    output in_ready, out_valid, lt, eq, gt, out_tag
  );

  modport master (
    output in_valid, a, b, sgn, in_tag, out_ready,
    input  in_ready, out_valid, lt, eq, gt, out_tag
  );

endinterface

// File: rtl/cmp_merge.sv
// Combinational merge of two adjacent lt/eq/gt triples: the high half decides
// unless it is equal, in which case the low half decides.
module cmp_merge
  import cmp_pipe_pkg::*;
(
  input  triple_t low,
  input  triple_t high,
  output triple_t merged
);

  always_comb begin
    merged         = '0;
    merged[CMP_LT] = high[CMP_EQ] ? low[CMP_LT] : high[CMP_LT];
    merged[CMP_EQ] = low[CMP_EQ] & high[CMP_EQ];
    merged[CMP_GT] = high[CMP_EQ] ? low[CMP_GT] : high[CMP_GT];
  end

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined W = 2**ORDER bit magnitude comparator: one reduction-tree level per
// register stage, with an elastic valid/ready chain so bubbles collapse.
module cmp_pipe
  import cmp_pipe_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int TW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  cmp_pipe_if.slave  bus
);

  localparam int W      = 1 << ORDER;
  localparam int FLAT_W = TRIPLE_W * (2 * W - 1);
  localparam int TOP    = TRIPLE_W * (2 * W - 2);

  logic [ORDER:0]   v;
  logic [ORDER+1:0] adv;
  logic [TW-1:0]    tag_q [ORDER+1];
  // All stage registers laid out back to back: stage k of W>>k triples
  // starts at triple offset 2W - 2(W>>k).
  logic [FLAT_W-1:0] flags;

  always_comb begin
    adv          = '0;
    adv[ORDER+1] = bus.out_ready;
    for (int k = ORDER; k >= 0; k--) begin
      adv[k] = ~v[k] | adv[k+1];
    end
  end

  assign bus.in_ready = adv[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else begin
      if (adv[0]) v[0] <= bus.in_valid;
      for (int k = 1; k <= ORDER; k++) begin
        if (adv[k]) v[k] <= v[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv[0]) tag_q[0] <= bus.in_tag;
    for (int k = 1; k <= ORDER; k++) begin
      if (adv[k]) tag_q[k] <= tag_q[k-1];
    end
  end

  for (genvar k = 0; k <= ORDER; k++) begin : g_stage
    localparam int N   = W >> k;
    localparam int OFF = TRIPLE_W * (2 * W - 2 * N);

    logic [TRIPLE_W*N-1:0] d;
    logic [TRIPLE_W*N-1:0] q;

    if (k == 0) begin : g_leaf
      always_comb begin
        d = '0;
        for (int i = 0; i < W; i++) begin
          d[TRIPLE_W*i +: TRIPLE_W] = leaf_triple(bus.a[i], bus.b[i]);
        end
        if (bus.sgn) begin
          d[TRIPLE_W*(W-1) +: TRIPLE_W] = swap_order(leaf_triple(bus.a[W-1], bus.b[W-1]));
        end
      end
    end else begin : g_tree
      localparam int PREV = TRIPLE_W * (2 * W - 4 * N);
      for (genvar j = 0; j < N; j++) begin : g_pair
        cmp_merge u_merge (
          .low    (flags[PREV + TRIPLE_W*(2*j)   +: TRIPLE_W]),
          .high   (flags[PREV + TRIPLE_W*(2*j+1) +: TRIPLE_W]),
          .merged (d[TRIPLE_W*j +: TRIPLE_W])
        );
      end
    end

    always_ff @(posedge clk) begin
      if (adv[k]) q <= d;
    end

    assign flags[OFF +: TRIPLE_W*N] = q;
  end

  // Data registers are never reset, so everything visible is gated by valid.
  assign bus.out_valid = v[ORDER];
  assign bus.lt        = v[ORDER] & flags[TOP + CMP_LT];
  assign bus.eq        = v[ORDER] & flags[TOP + CMP_EQ];
  assign bus.gt        = v[ORDER] & flags[TOP + CMP_GT];
  assign bus.out_tag   = v[ORDER] ? tag_q[ORDER] : '0;

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe with ORDER = 3 (W = 8, L = 4), TW = 4.
module tb_cmp_pipe;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  cmp_pipe_if #(.ORDER(3), .TW(4)) bus ();

  cmp_pipe #(.ORDER(3), .TW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Hand-computed vectors; expected code is {gt, eq, lt}.
  localparam logic [7:0] VA [16] = '{8'h00, 8'h01, 8'h02, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h80,
                                     8'h3C, 8'hC3, 8'hC3, 8'h10, 8'hFE, 8'h55, 8'h55, 8'h00};
  localparam logic [7:0] VB [16] = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h80, 8'h80, 8'h81,
                                     8'h3C, 8'h3C, 8'h3C, 8'h01, 8'hFF, 8'hAA, 8'hAA, 8'h80};
  localparam logic       VS [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [2:0] VE [16] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b001, 3'b100, 3'b001, 3'b001,
                                     3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] opa, input logic [7:0] opb,
                               input logic s, input logic [3:0] tag, input logic rdy);
    bus.in_valid  = valid;
    bus.a         = opa;
    bus.b         = opb;
    bus.sgn       = s;
    bus.in_tag    = tag;
    bus.out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Presented in cycle c, the result must be visible in cycle c+4 and not before.
  task automatic runSingle(input string name, input logic [7:0] opa, input logic [7:0] opb,
                           input logic s, input logic [3:0] tag, input logic [2:0] expect_flags);
    applyStimulus(1'b1, opa, opb, s, tag, 1'b1);
    #1;
    checkOutput({name, "_in_ready"}, bus.in_ready, 1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1);
    repeat (3) begin
      checkOutput({name, "_early"}, bus.out_valid, 0);
      tick();
    end
    checkOutput({name, "_valid"}, bus.out_valid, 1);
    checkOutput({name, "_flags"}, {bus.gt, bus.eq, bus.lt}, expect_flags);
    checkOutput({name, "_tag"}, bus.out_tag, tag);
    tick();
  endtask

  initial begin
    int src;
    int outs;

    // Reset held with a valid input: nothing may be accepted or appear.
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b0, 4'hF, 1'b1);
    reset = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("reset_hold_valid", bus.out_valid, 0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1);
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_flags", {bus.gt, bus.eq, bus.lt}, 3'b000);
    checkOutput("reset_out_tag", bus.out_tag, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    repeat (5) begin
      tick();
      checkOutput("reset_no_result", bus.out_valid, 0);
    end

    // Signed versus unsigned on the same operands, plus equality and negatives.
    runSingle("u80_7f", 8'h80, 8'h7F, 1'b0, 4'h1, 3'b100);
    runSingle("s80_7f", 8'h80, 8'h7F, 1'b1, 4'h2, 3'b001);
    runSingle("eq_a5", 8'hA5, 8'hA5, 1'b0, 4'h3, 3'b010);
    runSingle("sff_fe", 8'hFF, 8'hFE, 1'b1, 4'h4, 3'b100);

    // Back-to-back stream at full throughput.
    for (int c = 0; c < 20; c++) begin
      if (c < 16) applyStimulus(1'b1, VA[c], VB[c], VS[c], 4'(c), 1'b1);
      else        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1);
      #1;
      if (c >= 4) begin
        checkOutput("stream_valid", bus.out_valid, 1);
        checkOutput("stream_flags", {bus.gt, bus.eq, bus.lt}, VE[c-4]);
        checkOutput("stream_tag", bus.out_tag, c - 4);
      end else begin
        checkOutput("stream_fill", bus.out_valid, 0);
      end
      tick();
    end

    // Output stalled for 10 cycles: exactly L inputs fit, head result held steady.
    src = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, VA[src % 16], VB[src % 16], VS[src % 16], 4'(src), 1'b0);
      #1;
      if (bus.out_valid) begin
        checkOutput("stall_hold_flags", {bus.gt, bus.eq, bus.lt}, VE[0]);
        checkOutput("stall_hold_tag", bus.out_tag, 0);
      end
      if (bus.in_ready) src++;
      tick();
    end
    checkOutput("stall_accepted", src, 4);
    applyStimulus(1'b1, VA[src % 16], VB[src % 16], VS[src % 16], 4'(src), 1'b0);
    #1;
    checkOutput("stall_in_ready", bus.in_ready, 0);
    checkOutput("stall_out_valid", bus.out_valid, 1);

    // Release: drain in order and continue the stream without loss or duplicates.
    outs = 0;
    for (int c = 0; c < 30; c++) begin
      if (src < 16) applyStimulus(1'b1, VA[src], VB[src], VS[src], 4'(src), 1'b1);
      else          applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1);
      #1;
      if (bus.out_valid) begin
        if (outs < 16) begin
          checkOutput("drain_flags", {bus.gt, bus.eq, bus.lt}, VE[outs]);
          checkOutput("drain_tag", bus.out_tag, outs);
        end
        outs++;
      end
      if (src < 16 && bus.in_ready) src++;
      tick();
    end
    checkOutput("drain_count", outs, 16);
    checkOutput("drain_accepted", src, 16);
    checkOutput("drain_empty", bus.out_valid, 0);

    // Reset with three transactions in flight and a valid input in the reset cycle.
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, VA[c], VB[c], VS[c], 4'(c), 1'b1);
      tick();
    end
    reset = 1'b1;
    applyStimulus(1'b1, 8'h00, 8'h80, 1'b1, 4'h9, 1'b1);
    tick();
    checkOutput("midreset_out_valid", bus.out_valid, 0);
    checkOutput("midreset_flags", {bus.gt, bus.eq, bus.lt}, 3'b000);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1);
    repeat (5) begin
      tick();
      checkOutput("midreset_flushed", bus.out_valid, 0);
    end
    runSingle("after_reset", 8'h80, 8'h7F, 1'b1, 4'h5, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
